// File: rtl/mmcm_ps_pkg.sv
// Shared definitions for the MMCM dynamic phase-shift responder:
// one-hot state encoding, default timing/size constants and the position type.
package mmcm_ps_pkg;

    localparam int PS_STEPS_DEFAULT   = 448;
    localparam int PS_LATENCY_DEFAULT = 12;

    // Latency counter width; covers the full 2..255 latency range.
    localparam int LAT_W = 8;

    typedef logic [15:0] ps_pos_t;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        DONE = 3'b100
    } ps_state_e;

endpackage

// File: rtl/mmcm_ps_responder_if.sv
// psen/psincdec/psdone/ps_busy handshake between a phase-shift initiator
// (master) and the MMCM-side responder (slave).
interface mmcm_ps_responder_if;

    logic psen;
    logic psincdec;
    logic psdone;
    logic ps_busy;

    modport master (
        output psen,
        output psincdec,
        input  psdone,
        input  ps_busy
    );

    modport slave (
        input  psen,
        input  psincdec,
        output psdone,
        output ps_busy
    );

endinterface

// File: rtl/mmcm_ps_pos_tracker.sv
// Modulo-PS_STEPS up/down phase position register. A step moves the position
// by one in the requested direction; crossing the ends produces a one-cycle
// wrap pulse registered together with the new position.
module mmcm_ps_pos_tracker
    import mmcm_ps_pkg::*;
#(
    parameter int PS_STEPS = PS_STEPS_DEFAULT,
    parameter int POS_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             step_i,
    input  logic             inc_i,
    output logic [POS_W-1:0] pos_o,
    output logic             wrap_o
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(PS_STEPS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap_q, wrap_d;

    // Next position: compare against the ends first so no value beyond PS_STEPS-1 is ever formed.
    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (step_i) begin
            if (inc_i) begin
                if (pos_q == POS_LAST) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d  = POS_LAST;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - POS_ONE;
                end
            end
        end
    end

    // Position and wrap registers; reset returns the phase to zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
        end
    end

    assign pos_o  = pos_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/mmcm_ps_responder.sv
// MMCM-side model of the dynamic phase-shift port. Accepts a psen pulse in
// IDLE, waits a fixed latency, answers with a one-cycle psdone and updates the
// tracked phase position. psen seen while a step is in flight is ignored and
// recorded in a sticky overlap flag.
module mmcm_ps_responder
    import mmcm_ps_pkg::*;
#(
    parameter int PS_LATENCY = PS_LATENCY_DEFAULT,
    parameter int PS_STEPS   = PS_STEPS_DEFAULT,
    parameter int POS_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    mmcm_ps_responder_if.slave  ps_if,
    input  logic                clr_err,
    output logic [POS_W-1:0]    ps_pos,
    output logic                pos_wrap,
    output logic [15:0]         ps_step_cnt,
    output logic                ps_err_overlap
);

    // Loading PS_LATENCY-1 and leaving BUSY at 1 places psdone exactly
    // PS_LATENCY edges after the edge that sampled psen.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(PS_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    ps_state_e        state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             dir_q, dir_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             step;
    logic             overlap;

    // Request FSM: accept in IDLE, count down in BUSY, one DONE cycle; step commits on BUSY->DONE.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        dir_d     = dir_q;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ps_if.psen) begin
                    dir_d     = ps_if.psincdec;
                    lat_cnt_d = LAT_LOAD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                lat_cnt_d = lat_cnt_q - LAT_ONE;
                if (lat_cnt_q == LAT_ONE) begin
                    state_d = DONE;
                    step    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign overlap = ps_if.psen && (state_q != IDLE);

    // Step counter and overlap flag; a coinciding step beats clear for the counter, set beats clear for the flag.
    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            if (clr_err) begin
                cnt_d = 16'd1;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (clr_err) begin
            cnt_d = '0;
        end

        err_d = err_q;
        if (overlap) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // Control and counter registers; reset aborts any step in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    mmcm_ps_pos_tracker #(
        .PS_STEPS (PS_STEPS),
        .POS_W    (POS_W)
    ) u_pos (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .step_i  (step),
        .inc_i   (dir_q),
        .pos_o   (ps_pos),
        .wrap_o  (pos_wrap)
    );

    assign ps_if.psdone  = (state_q == DONE);
    assign ps_if.ps_busy = (state_q == BUSY) || (state_q == DONE);
    assign ps_step_cnt    = cnt_q;
    assign ps_err_overlap = err_q;

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Directed bench for mmcm_ps_responder. Every legal request pushes its
// expected completion (edge, position, wrap, count) to a scoreboard; the
// psdone monitor pops and compares.
module tb_mmcm_ps_responder;
    import mmcm_ps_pkg::*;

    localparam int LAT   = 12;
    localparam int STEPS = 448;

    typedef struct {
        int          edge_n;
        logic [15:0] pos;
        logic        wrap;
        logic [15:0] cnt;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr_err = 1'b0;
    ps_pos_t     ps_pos;
    logic        pos_wrap;
    logic [15:0] ps_step_cnt;
    logic        ps_err_overlap;

    mmcm_ps_responder_if ps_if ();

    mmcm_ps_responder #(
        .PS_LATENCY (LAT),
        .PS_STEPS   (STEPS),
        .POS_W      (16)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .ps_if          (ps_if),
        .clr_err        (clr_err),
        .ps_pos         (ps_pos),
        .pos_wrap       (pos_wrap),
        .ps_step_cnt    (ps_step_cnt),
        .ps_err_overlap (ps_err_overlap)
    );

    always #5 clk = ~clk;

    int   ecnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;
    int   wrap_seen = 0;
    int   n_issued = 0;
    int   m_pos = 0;
    int   m_cnt = 0;
    int   e_edge = 0;

    always @(posedge clk) ecnt = ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // psdone monitor: every completion must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wrap_only_with_done", 32'(pos_wrap & ~ps_if.psdone), 32'd0);
            if (ps_if.psdone) begin
                done_seen++;
                if (pos_wrap) wrap_seen++;
                chk("psdone_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("done_edge", 32'(ecnt + 1), 32'(mon_e.edge_n));
                    chk("done_pos", 32'(ps_pos), 32'(mon_e.pos));
                    chk("done_wrap", 32'(pos_wrap), 32'(mon_e.wrap));
                    chk("done_cnt", 32'(ps_step_cnt), 32'(mon_e.cnt));
                    chk("done_busy", 32'(ps_if.ps_busy), 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raw psen pulse with no scoreboard entry (aborted or overlapping requests)
    task automatic pulse(input logic dir);
        ps_if.psen     = 1'b1;
        ps_if.psincdec = dir;
        tick();
        ps_if.psen     = 1'b0;
        ps_if.psincdec = 1'($urandom);
    endtask

    // Legal request: advance the model and queue the expected completion
    task automatic issue(input logic dir);
        exp_t e;
        e.wrap = 1'b0;
        if (dir) begin
            if (m_pos == STEPS - 1) begin m_pos = 0; e.wrap = 1'b1; end
            else m_pos = m_pos + 1;
        end else begin
            if (m_pos == 0) begin m_pos = STEPS - 1; e.wrap = 1'b1; end
            else m_pos = m_pos - 1;
        end
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        e.pos    = 16'(m_pos);
        e.cnt    = 16'(m_cnt);
        e.edge_n = ecnt + 1 + LAT;
        e_edge   = ecnt + 1;
        sb.push_back(e);
        n_issued++;
        pulse(dir);
    endtask

    // Returns one tick after the psdone cycle, i.e. in the first IDLE cycle
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_done_in_budget", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_pos = 0;
        m_cnt = 0;
        tick();
    endtask

    initial begin
        ps_if.psen     = 1'b0;
        ps_if.psincdec = 1'b0;
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_psdone", 32'(ps_if.psdone), 32'd0);
        chk("rst_busy", 32'(ps_if.ps_busy), 32'd0);
        chk("rst_wrap", 32'(pos_wrap), 32'd0);
        chk("rst_err", 32'(ps_err_overlap), 32'd0);
        chk("rst_pos", 32'(ps_pos), 32'd0);
        chk("rst_cnt", 32'(ps_step_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // single increment with per-cycle busy window
        issue(1'b1);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("busy_window", 32'(ps_if.ps_busy), 32'((ecnt >= e_edge) && (ecnt <= e_edge + LAT - 1)));
        end
        wait_idle();
        chk("inc_pos", 32'(ps_pos), 32'd1);
        chk("inc_cnt", 32'(ps_step_cnt), 32'd1);
        chk("inc_err", 32'(ps_err_overlap), 32'd0);

        // decrement wrap from zero
        do_reset();
        issue(1'b0);
        wait_idle();
        chk("dec_wrap_pos", 32'(ps_pos), 32'(STEPS - 1));

        // full revolution of back-to-back increments
        do_reset();
        wrap_seen = 0;
        for (int i = 0; i < STEPS; i++) begin
            issue(1'b1);
            wait_idle();
        end
        chk("rev_wraps", 32'(wrap_seen), 32'd1);
        chk("rev_pos", 32'(ps_pos), 32'd0);
        chk("rev_cnt", 32'(ps_step_cnt), 32'(STEPS));

        // overlapping requests mid-step and in the DONE cycle
        issue(1'b1);
        repeat (4) tick();
        pulse(1'b0);
        repeat (6) tick();
        pulse(1'b1);
        chk("ovl_err_set", 32'(ps_err_overlap), 32'd1);
        chk("ovl_busy_dropped", 32'(ps_if.ps_busy), 32'd0);
        chk("ovl_sb_drained", 32'(sb.size()), 32'd0);
        repeat (3) tick();
        chk("ovl_busy_idle", 32'(ps_if.ps_busy), 32'd0);
        chk("ovl_pos", 32'(ps_pos), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_cnt = 0;
        chk("clr_err", 32'(ps_err_overlap), 32'd0);
        chk("clr_cnt", 32'(ps_step_cnt), 32'd0);

        // reset in the middle of a step
        pulse(1'b1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_psdone", 32'(ps_if.psdone), 32'd0);
        tick();
        rst_n = 1'b1;
        m_pos = 0;
        m_cnt = 0;
        chk("midrst_pos", 32'(ps_pos), 32'd0);
        chk("midrst_busy", 32'(ps_if.ps_busy), 32'd0);
        chk("midrst_cnt", 32'(ps_step_cnt), 32'd0);
        repeat (15) tick();
        issue(1'b1);
        wait_idle();

        // clear coinciding with a committing step
        repeat (4) begin
            issue(1'b1);
            wait_idle();
        end
        chk("pre_clr_cnt", 32'(ps_step_cnt), 32'd5);
        m_cnt = 0;
        issue(1'b1);
        repeat (10) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        wait_idle();
        chk("clr_step_cnt", 32'(ps_step_cnt), 32'd1);

        // clear coinciding with an overlap psen
        m_cnt = 0;
        issue(1'b0);
        repeat (2) tick();
        ps_if.psen = 1'b1;
        clr_err    = 1'b1;
        tick();
        ps_if.psen = 1'b0;
        clr_err    = 1'b0;
        chk("set_beats_clr", 32'(ps_err_overlap), 32'd1);
        wait_idle();
        chk("set_beats_clr_hold", 32'(ps_err_overlap), 32'd1);
        chk("final_pos", 32'(ps_pos), 32'd5);

        repeat (5) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(n_issued));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmcm_ps_responder.md
Name: mmcm_ps_responder

Overview:
Synthesizable responder for the MMCM dynamic phase-shift port. It sits in the psclk domain and models the MMCM side of the psen/psincdec/psdone handshake. It answers each accepted psen pulse with a one-cycle psdone after a fixed latency and tracks the resulting phase position. It also flags protocol violations. Used as a loopback target for the phase-shift initiator in bring-up builds and in block-level benches.

Parameters:
PS_LATENCY, 12, cycles from sampled psen to psdone; legal range 2..255
PS_STEPS, 448, phase steps per full VCO period (56 x 8); legal range 2..2**POS_W
POS_W, 16, width of the phase position output

Ports:
clk_i  in  1  psclk; all logic on rising edge
rst_n_i  in  1  asynchronous, active-low reset
psen  in  1  phase-shift request; one-cycle pulse expected
psincdec  in  1  direction, sampled with psen; 1 = increment, 0 = decrement
psdone  out  1  one-cycle completion pulse
ps_busy  out  1  high from the cycle after psen is accepted through the psdone cycle
ps_pos  out  POS_W  current phase position, 0..PS_STEPS-1
pos_wrap  out  1  one-cycle pulse, coincident with psdone, when ps_pos wraps
ps_step_cnt  out  16  count of completed steps, saturating at 16'hFFFF
ps_err_overlap  out  1  sticky flag: psen seen while busy
clr_err  in  1  synchronous clear for ps_err_overlap and ps_step_cnt

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - psdone, ps_busy, pos_wrap and ps_err_overlap = 0
  - ps_pos = 0, ps_step_cnt = 0, state = IDLE, latency counter = 0
- FSM states are one-hot: IDLE, BUSY, DONE.
- IDLE:
  - psen=1 at edge N: latch psincdec, load lat_cnt = PS_LATENCY-1, go to BUSY.
  - ps_busy = 1 from cycle N+1.
- BUSY:
  - Decrement lat_cnt each cycle.
  - When lat_cnt reaches 1, go to DONE.
- DONE (exactly one cycle):
  - psdone = 1 during cycle N+PS_LATENCY.
  - ps_pos, pos_wrap and ps_step_cnt take their new values in the same cycle.
  - Next state is IDLE.
  - ps_busy drops to 0 in the cycle after psdone.
- Latency is exactly PS_LATENCY cycles from psen edge to psdone edge, for every step.
- Position arithmetic:
  - Increment: pos == PS_STEPS-1 gives 0 with pos_wrap=1; otherwise pos+1.
  - Decrement: pos == 0 gives PS_STEPS-1 with pos_wrap=1; otherwise pos-1.
  - No intermediate value ever exceeds PS_STEPS-1.
- ps_step_cnt increments on each psdone and holds at 16'hFFFF.
- Overlap:
  - psen=1 while in BUSY or DONE is ignored: no new request, the direction latch is unchanged, the timing of the in-flight step is unaffected.
  - ps_err_overlap is set to 1 on the next edge.
  - psen in the first IDLE cycle after DONE is legal.
- Held psen (multi-cycle high): the first cycle is accepted and the remaining cycles count as overlap.
- psincdec is don't-care when psen=0.
- clr_err: clears ps_err_overlap and ps_step_cnt on the next edge.
  - If set and clear coincide, set wins for ps_err_overlap.
  - If step and clear coincide, ps_step_cnt = 1.
- Reset mid-operation aborts the step: no psdone is generated and ps_pos returns to 0.

Decomposition:
- Shared package mmcm_ps_pkg holds:
  - the state encoding constants (IDLE/BUSY/DONE one-hot)
  - PS_STEPS_DEFAULT = 448
  - PS_LATENCY_DEFAULT = 12
  - typedef ps_pos_t (logic [15:0])
- One sub-module, mmcm_ps_pos_tracker: the modulo-PS_STEPS up/down position register with wrap pulse.
- The FSM and counters stay in the top module.

Test Plan:
- Single increment: reset, psen=1 with psincdec=1 at edge 10 -> psdone=1 only in cycle 22; ps_busy high cycles 11..22; ps_pos 0->1; ps_step_cnt=1; pos_wrap=0.
- Decrement wrap: from reset, one psen with psincdec=0 -> psdone after 12 cycles, ps_pos=447, pos_wrap=1 in the same cycle as psdone.
- Increment wrap: 448 back-to-back legal increments (each issued the cycle after busy drops) -> ps_pos returns to 0, pos_wrap pulses exactly once, ps_step_cnt=448.
- Overlap: psen at edge 10, second psen at edge 15 and third at edge 22 (the DONE cycle) -> single psdone at cycle 22, ps_pos=1, ps_err_overlap=1; clr_err then gives err=0 and cnt=0.
- Reset mid-step: psen at edge 10, rst_n_i low at cycle 16 for 2 cycles -> no psdone; ps_pos=0, ps_busy=0; next psen completes after exactly 12 cycles.
- Simultaneous clr_err and psdone: clr_err in the psdone cycle with cnt=5 -> ps_step_cnt=1; clr_err together with an overlap psen -> ps_err_overlap stays 1.
